// File: rtl/pcie_rx_if.sv
// Bundles the RX AXI-stream beat bus and the decoded write/read/completion outputs of pcie_rx.
// master: the pcie_rx side. slave: the PCIe core / register-file side.
interface pcie_rx_if #(
  parameter int ADDR_W = 13
);
  logic [63:0]       rx_tdata;
  logic              rx_tvalid;
  logic              rx_tlast;
  logic              rx_tready;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_rid_tag;
  logic [3:0]        rd_lower_addr;

  logic              cpl_valid;
  logic [63:0]       cpl_data;
  logic [7:0]        cpl_tag;
  logic [6:0]        cpl_addr;

  modport master (
    input  rx_tdata, rx_tvalid, rx_tlast, rd_ready,
    output rx_tready,
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr, rd_rid_tag, rd_lower_addr,
    output cpl_valid, cpl_data, cpl_tag, cpl_addr
  );

  modport slave (
    output rx_tdata, rx_tvalid, rx_tlast, rd_ready,
    input  rx_tready,
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr, rd_rid_tag, rd_lower_addr,
    input  cpl_valid, cpl_data, cpl_tag, cpl_addr
  );
endinterface

// File: rtl/pcie_rx.sv
// PCIe RX TLP decoder: MWr (1 DW) -> register write, CplD -> realigned qwords, MRd -> pending read.
// MRd handling is present only when PCIE_RX_REGREAD_EN is defined; otherwise MRd TLPs are discarded.
module pcie_rx #(
  parameter int ADDR_W = 13
) (
  input logic       clock,
  input logic       reset_n,
  pcie_rx_if.master bus
);

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, CPL_DATA, DISCARD} state_t;
  typedef enum logic [1:0] {K_MWR, K_MRD, K_CPLD} kind_t;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t            state;
  kind_t             kind;
  logic              four_dw;
  logic [9:0]        len_q;
  logic [31:0]       hold;
  logic [9:0]        rem;
  logic [6:0]        cpl_next;
  logic [7:0]        tag_q;
  logic [ADDR_W-1:0] addr_q;

  logic [1:0] hdr_fmt;
  logic [4:0] hdr_type;
  logic [9:0] hdr_len;
  logic       is_mwr, is_mrd, is_cpld, beat;

  always_comb begin
    hdr_fmt  = bus.rx_tdata[30:29];
    hdr_type = bus.rx_tdata[28:24];
    hdr_len  = bus.rx_tdata[9:0];
    is_mwr   = (hdr_type == 5'b00000) && hdr_fmt[1] && (hdr_len == 10'd1);
    is_cpld  = (hdr_fmt == 2'b10) && (hdr_type == 5'b01010);
`ifdef PCIE_RX_REGREAD_EN
    is_mrd   = (hdr_type == 5'b00000) && !hdr_fmt[1] &&
               ((hdr_len == 10'd1) || (hdr_len == 10'd2));
`else
    is_mrd   = 1'b0;
`endif
    beat     = bus.rx_tvalid && bus.rx_tready;
  end

`ifdef PCIE_RX_REGREAD_EN
  logic [23:0] rid_q;
  assign bus.rx_tready = ~bus.rd_valid;
`else
  logic unused_rd_ready;
  assign unused_rd_ready   = bus.rd_ready;
  assign bus.rx_tready     = 1'b1;
  assign bus.rd_valid      = 1'b0;
  assign bus.rd_addr       = '0;
  assign bus.rd_rid_tag    = '0;
  assign bus.rd_lower_addr = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HDR0;
      kind          <= K_MWR;
      four_dw       <= 1'b0;
      len_q         <= '0;
      hold          <= '0;
      rem           <= '0;
      cpl_next      <= '0;
      tag_q         <= '0;
      addr_q        <= '0;
      bus.wr_valid  <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.cpl_valid <= 1'b0;
      bus.cpl_data  <= '0;
      bus.cpl_tag   <= '0;
      bus.cpl_addr  <= '0;
`ifdef PCIE_RX_REGREAD_EN
      rid_q             <= '0;
      bus.rd_valid      <= 1'b0;
      bus.rd_addr       <= '0;
      bus.rd_rid_tag    <= '0;
      bus.rd_lower_addr <= '0;
`endif
    end else begin
      bus.wr_valid  <= 1'b0;
      bus.cpl_valid <= 1'b0;
`ifdef PCIE_RX_REGREAD_EN
      if (bus.rd_valid && bus.rd_ready) bus.rd_valid <= 1'b0;
`endif
      if (beat) begin
        case (state)
          HDR0: begin
            four_dw <= hdr_fmt[0];
            len_q   <= hdr_len;
`ifdef PCIE_RX_REGREAD_EN
            rid_q   <= bus.rx_tdata[63:40];
`endif
            if (is_cpld)     kind <= K_CPLD;
            else if (is_mrd) kind <= K_MRD;
            else             kind <= K_MWR;
            if (bus.rx_tlast)                   state <= HDR0;
            else if (is_mwr || is_mrd || is_cpld) state <= HDR1;
            else                                state <= DISCARD;
          end
          HDR1: begin
            case (kind)
              K_MWR: begin
                if (four_dw) begin
                  // 4DW write: payload arrives in the next beat, keep the address
                  addr_q <= bus.rx_tdata[ADDR_W+33:34];
                  state  <= bus.rx_tlast ? HDR0 : HDR2;
                end else begin
                  bus.wr_valid <= 1'b1;
                  bus.wr_addr  <= bus.rx_tdata[ADDR_W+1:2];
                  bus.wr_data  <= bswap(bus.rx_tdata[63:32]);
                  state        <= bus.rx_tlast ? HDR0 : DISCARD;
                end
              end
`ifdef PCIE_RX_REGREAD_EN
              K_MRD: begin
                bus.rd_valid      <= 1'b1;
                bus.rd_rid_tag    <= rid_q;
                bus.rd_addr       <= four_dw ? bus.rx_tdata[ADDR_W+33:34] : bus.rx_tdata[ADDR_W+1:2];
                bus.rd_lower_addr <= four_dw ? bus.rx_tdata[38:35] : bus.rx_tdata[6:3];
                state             <= bus.rx_tlast ? HDR0 : DISCARD;
              end
`endif
              K_CPLD: begin
                tag_q    <= bus.rx_tdata[15:8];
                cpl_next <= bus.rx_tdata[6:0];
                hold     <= bus.rx_tdata[63:32];
                // length field 0 encodes 1024 DW
                rem      <= (len_q == 10'd0) ? 10'd512 : {1'b0, len_q[9:1]};
                if (bus.rx_tlast)          state <= HDR0;
                else if (len_q == 10'd1)   state <= DISCARD;
                else                       state <= CPL_DATA;
              end
              default: state <= bus.rx_tlast ? HDR0 : DISCARD;
            endcase
          end
          HDR2: begin
            bus.wr_valid <= 1'b1;
            bus.wr_addr  <= addr_q;
            bus.wr_data  <= bswap(bus.rx_tdata[31:0]);
            state        <= bus.rx_tlast ? HDR0 : DISCARD;
          end
          CPL_DATA: begin
            if (rem != 10'd0) begin
              bus.cpl_valid <= 1'b1;
              bus.cpl_data  <= {bswap(bus.rx_tdata[31:0]), bswap(hold)};
              bus.cpl_tag   <= tag_q;
              bus.cpl_addr  <= cpl_next;
              cpl_next      <= cpl_next + 7'd8;
              rem           <= rem - 10'd1;
            end
            hold <= bus.rx_tdata[63:32];
            if (bus.rx_tlast)         state <= HDR0;
            else if (rem <= 10'd1)    state <= DISCARD;
          end
          DISCARD: begin
            if (bus.rx_tlast) state <= HDR0;
          end
          default: state <= HDR0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcie_rx.sv
// Directed bench for pcie_rx: writes, reads, completions, discards, reset mid-TLP, stalled beats.
module tb_pcie_rx;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clock = ~clock;

  pcie_rx_if #(.ADDR_W(13)) bus ();

  pcie_rx #(.ADDR_W(13)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic l);
    int unsigned n = 0;
    bus.rx_tdata  = d;
    bus.rx_tvalid = 1'b1;
    bus.rx_tlast  = l;
    while (!bus.rx_tready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) chk("tready_wait", {63'd0, bus.rx_tready}, 64'd1);
    @(posedge clock); #1;
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic chk_none(input string tag);
    chk(tag, {61'd0, bus.wr_valid, bus.cpl_valid, bus.rd_valid}, 64'd0);
  endtask

  task automatic mwr32(input string tag, input logic [31:0] addr, input logic [31:0] raw,
                       input logic [12:0] ea, input logic [31:0] ed);
    beat({32'h0000000F, 32'h40000001}, 1'b0);
    chk({tag, "_hdr_quiet"}, {63'd0, bus.wr_valid}, 64'd0);
    beat({raw, addr}, 1'b1);
    chk({tag, "_wr_valid"}, {63'd0, bus.wr_valid}, 64'd1);
    chk({tag, "_wr_addr"}, {51'd0, bus.wr_addr}, {51'd0, ea});
    chk({tag, "_wr_data"}, {32'd0, bus.wr_data}, {32'd0, ed});
    idle(1);
    chk({tag, "_strobe_end"}, {63'd0, bus.wr_valid}, 64'd0);
  endtask

  function automatic logic [31:0] dk(input int unsigned k);
    return 32'h0A0B0C00 + k;
  endfunction

  logic [63:0] q8 [4];

  task automatic cpl8(input string tag, input bit gap);
    beat({32'h00000020, 32'h4A000008}, 1'b0);
    if (gap) idle(1);
    beat({dk(0), 32'h00000540}, 1'b0);
    chk({tag, "_hdr_quiet"}, {63'd0, bus.cpl_valid}, 64'd0);
    for (int unsigned j = 0; j < 4; j++) begin
      if (gap) begin
        idle(1);
        chk({tag, "_gap_quiet"}, {63'd0, bus.cpl_valid}, 64'd0);
      end
      beat({(j == 3) ? 32'hDEADBEEF : dk(2*j+2), dk(2*j+1)}, j == 3);
      chk({tag, "_valid"}, {63'd0, bus.cpl_valid}, 64'd1);
      chk({tag, "_addr"}, {57'd0, bus.cpl_addr}, {57'd0, 7'h40 + 7'(8*j)});
      chk({tag, "_tag"}, {56'd0, bus.cpl_tag}, 64'h05);
      chk({tag, "_data"}, bus.cpl_data, q8[j]);
    end
    idle(1);
    chk({tag, "_end"}, {63'd0, bus.cpl_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    q8[0] = 64'h010C0B0A_000C0B0A;
    q8[1] = 64'h030C0B0A_020C0B0A;
    q8[2] = 64'h050C0B0A_040C0B0A;
    q8[3] = 64'h070C0B0A_060C0B0A;
    bus.rx_tdata  = '0;
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
    bus.rd_ready  = 1'b0;

    // reset state
    #3 reset_n = 1'b0;
    #10;
    chk("rst_valids", {61'd0, bus.wr_valid, bus.cpl_valid, bus.rd_valid}, 64'd0);
    chk("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
    chk("rst_cpl_data", bus.cpl_data, 64'd0);
    chk("rst_tready", {63'd0, bus.rx_tready}, 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(1);

    // MWr32 len 1 at 0x10, bytes 11 22 33 44
    mwr32("mwr32", 32'h00000010, 32'h11223344, 13'h004, 32'h44332211);

    // MRd64 len 2 at 0x1_0000_0048, req 0x0100 tag 0x07
    beat({32'h010007FF, 32'h20000002}, 1'b0);
    chk_none("mrd_hdr0_quiet");
    beat({32'h00000048, 32'h00000001}, 1'b1);
`ifdef PCIE_RX_REGREAD_EN
    chk("mrd_rid_tag", {40'd0, bus.rd_rid_tag}, 64'h010007);
    chk("mrd_lower", {60'd0, bus.rd_lower_addr}, 64'd9);
    chk("mrd_addr", {51'd0, bus.rd_addr}, 64'h12);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("mrd_pending", {62'd0, bus.rd_valid, bus.rx_tready}, 64'b10);
      idle(1);
    end
    bus.rd_ready = 1'b1;
    idle(1);
    bus.rd_ready = 1'b0;
    chk("mrd_released", {62'd0, bus.rd_valid, bus.rx_tready}, 64'b01);
`else
    chk("mrd_discard", {62'd0, bus.rd_valid, bus.rx_tready}, 64'b01);
    chk("mrd_rid_tied", {40'd0, bus.rd_rid_tag}, 64'd0);
    idle(1);
    chk_none("mrd_discard_quiet");
`endif

    // CplD tag 5, lower 0x40, len 8
    cpl8("cpl8", 1'b0);

    // vendor message (4 beats) then MWr32 back-to-back
    beat({32'h0000007F, 32'h74000004}, 1'b0);
    chk_none("msg_b0");
    beat({32'h12345678, 32'h9ABCDEF0}, 1'b0);
    chk_none("msg_b1");
    beat({32'h00000001, 32'h40000001}, 1'b0);
    chk_none("msg_b2");
    beat({32'hFFFFFFFF, 32'h00000010}, 1'b1);
    chk_none("msg_b3");
    mwr32("post_msg", 32'h00000104, 32'hAABBCCDD, 13'h041, 32'hDDCCBBAA);

    // reset asserted on 3rd beat of CplD len 16
    beat({32'h00000040, 32'h4A000010}, 1'b0);
    beat({dk(0), 32'h00000540}, 1'b0);
    bus.rx_tdata  = {dk(2), dk(1)};
    bus.rx_tvalid = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valids", {61'd0, bus.wr_valid, bus.cpl_valid, bus.rd_valid}, 64'd0);
    chk("midrst_wr", {19'd0, bus.wr_addr, bus.wr_data}, 64'd0);
    chk("midrst_cpl_data", bus.cpl_data, 64'd0);
    chk("midrst_cpl_meta", {49'd0, bus.cpl_tag, bus.cpl_addr}, 64'd0);
    bus.rx_tvalid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(1);
    mwr32("post_rst", 32'h00001FFC, 32'h01020304, 13'h7FF, 32'h04030201);

    // tvalid toggling during CplD len 8
    cpl8("cpl8_gap", 1'b1);

    // early tlast: CplD len 8 ends after D3
    beat({32'h00000020, 32'h4A000008}, 1'b0);
    beat({dk(0), 32'h00000540}, 1'b0);
    beat({dk(2), dk(1)}, 1'b0);
    chk("early_q0", bus.cpl_data, q8[0]);
    beat({dk(4), dk(3)}, 1'b1);
    chk("early_q1_valid", {63'd0, bus.cpl_valid}, 64'd1);
    chk("early_q1_addr", {57'd0, bus.cpl_addr}, 64'h48);
    idle(1);
    chk("early_end", {63'd0, bus.cpl_valid}, 64'd0);
    mwr32("post_early", 32'h00000020, 32'hCAFEF00D, 13'h008, 32'h0DF0FECA);

    // odd length 5, base 0x7C, tag 9: lone D4 dropped, cpl_addr wraps
    beat({32'h00000014, 32'h4A000005}, 1'b0);
    beat({dk(0), 32'h0000097C}, 1'b0);
    beat({dk(2), dk(1)}, 1'b0);
    chk("odd_q0_addr", {57'd0, bus.cpl_addr}, 64'h7C);
    chk("odd_q0_data", bus.cpl_data, q8[0]);
    beat({dk(4), dk(3)}, 1'b1);
    chk("odd_q1_valid", {63'd0, bus.cpl_valid}, 64'd1);
    chk("odd_q1_addr", {57'd0, bus.cpl_addr}, 64'h04);
    chk("odd_q1_tag", {56'd0, bus.cpl_tag}, 64'h09);
    chk("odd_q1_data", bus.cpl_data, q8[1]);
    idle(1);
    chk("odd_end", {63'd0, bus.cpl_valid}, 64'd0);

    // MWr64 len 1 at 0x1_0000_0020
    beat({32'h0000000F, 32'h60000001}, 1'b0);
    beat({32'h00000020, 32'h00000001}, 1'b0);
    chk("mwr64_hdr_quiet", {63'd0, bus.wr_valid}, 64'd0);
    beat({32'h00000000, 32'h55667788}, 1'b1);
    chk("mwr64_valid", {63'd0, bus.wr_valid}, 64'd1);
    chk("mwr64_addr", {51'd0, bus.wr_addr}, 64'h008);
    chk("mwr64_data", {32'd0, bus.wr_data}, 64'h88776655);

    // MWr32 len 2 is discarded
    beat({32'h0000000F, 32'h40000002}, 1'b0);
    chk("mwr_len2_b0", {63'd0, bus.wr_valid}, 64'd0);
    beat({32'h11111111, 32'h00000030}, 1'b0);
    chk("mwr_len2_b1", {63'd0, bus.wr_valid}, 64'd0);
    beat({32'h00000000, 32'h22222222}, 1'b1);
    chk("mwr_len2_b2", {63'd0, bus.wr_valid}, 64'd0);
    idle(1);
    chk_none("mwr_len2_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pcie_rx.md
PCIE_RX -- requirements
Module: pcie_rx

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, DW address bits presented on wr_addr/rd_addr.
REQ-002 SHALL have ports: clock  in  1  sole clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 rx_tdata  in  64  AXI-stream beat from PCIe core; {DW1,DW0} order, DW0 in [31:0].
REQ-005 rx_tvalid / rx_tlast  in  1 each  beat valid / last beat of TLP.
REQ-006 rx_tready  out  1  beat accepted when rx_tvalid && rx_tready.
REQ-007 wr_valid  out  1  one-cycle strobe: host register write; wr_addr out ADDR_W; wr_data out 32.
REQ-008 rd_valid  out  1  host register read pending; rd_ready in 1; rd_addr out ADDR_W; rd_rid_tag out 24 {requester ID, tag}; rd_lower_addr out 4 (address bits 6:3).
REQ-009 cpl_valid  out  1  one-cycle strobe per completion qword; cpl_data out 64; cpl_tag out 8; cpl_addr out 7 (byte lower address of qword).

Function
REQ-010 SHALL decode DW0 fmt[30:29]/type[28:24]/length[9:0]: MRd32 00/00000, MRd64 01/00000, MWr32 10/00000, MWr64 11/00000, CplD 10/01010; every other TLP SHALL be consumed to rx_tlast with no output.
REQ-011 States: HDR0, HDR1, HDR2 (4DW only), CPL_DATA, DISCARD; HDR0 after reset and after every accepted rx_tlast beat.
REQ-012 Each DW of payload SHALL be byte-swapped ({b0,b1,b2,b3}) before output; header DWs not swapped.
REQ-013 MWr with length==1: wr_addr = addr[ADDR_W+1:2], wr_data = swapped first DW; wr_valid pulses the cycle after the beat holding that DW. MWr with length!=1 SHALL be discarded.
REQ-014 MRd with length 1 or 2: rd_valid SHALL rise the cycle after the last header beat, holding rd_addr, rd_rid_tag = DW1[31:8], rd_lower_addr = addr[6:3] until rd_valid && rd_ready; other lengths discarded.
REQ-015 rx_tready SHALL equal ~rd_valid (combinational); no further beat accepted while a read is pending.
REQ-016 CplD: tag = DW2[15:8], base = DW2[6:0]; payload DW0 sits in beat 1 [63:32]; realign with a 32-bit holding register so qword j = {swap(D2j+1), swap(D2j)}.
REQ-017 cpl_valid SHALL pulse the cycle after the beat containing D2j+1; cpl_addr = base + 8*j (7-bit wrap); count = length/2 qwords; odd length SHALL drop the final lone DW.
REQ-018 rx_tvalid low SHALL not advance state or emit; tlast earlier than expected SHALL return to HDR0, emitting only fully received qwords.
REQ-019 wr_valid, cpl_valid, rd_valid SHALL never assert on the same beat as a header beat of a later TLP.

Reset
REQ-020 reset_n low SHALL immediately force state HDR0, wr_valid/rd_valid/cpl_valid 0, all data outputs 0, holding register 0.
REQ-021 Reset mid-TLP SHALL discard the partial TLP; first beat after release is treated as header.

Configuration
REQ-022 Macro PCIE_RX_REGREAD_EN: defined, MRd handled per REQ-014/015; undefined, MRd discarded, rd_valid/rd_addr/rd_rid_tag/rd_lower_addr tied 0, rx_tready tied 1.

Verification
REQ-023 MWr32 len 1, addr 0x0000_0010, data bytes 11 22 33 44 -> one wr_valid, wr_addr 4, wr_data 0x44332211.
REQ-024 MRd64 len 2, addr 0x1_0000_0048, req ID 0x0100, tag 0x07, rd_ready held low 5 cycles -> rd_valid steady, rx_tready 0 for those cycles, rd_rid_tag 0x010007, rd_lower_addr 9.
REQ-025 CplD tag 0x05, lower addr 0x40, len 8 -> 4 cpl_valid pulses, cpl_addr 0x40,0x48,0x50,0x58, data realigned and swapped.
REQ-026 Vendor message 4 beats followed back-to-back by MWr32 -> no output for message; write decoded correctly.
REQ-027 reset_n asserted on 3rd beat of CplD len 16 -> outputs 0 at once; next TLP after release decoded normally.
REQ-028 rx_tvalid toggling every other cycle during CplD len 8 -> identical 4 qwords as REQ-025.
